coprocessador_param: RTL and testbench
======================================

COPROCESSADOR_PARAM -- requirements
Module: coprocessador_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed two's-complement element width.
REQ-002 SHALL have parameter N_MAX, default 5: maximum matrix order; matrix bus width M_W = N_MAX*N_MAX*DATA_W.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: request; sampled only in IDLE.
REQ-006 SHALL have port tamanho, input, 3: matrix order n; valid range 2..N_MAX.
REQ-007 SHALL have port op, input, 3: opcode.
REQ-008 SHALL have ports matriz1 and matriz2, input, M_W: operands; element (i,j) at bits [(i*N_MAX+j)*DATA_W +: DATA_W].
REQ-009 SHALL have port matrizresult, output, M_W: result, same layout.
REQ-010 SHALL have port overflow, output, 1: sticky per operation; any result element not representable in DATA_W.
REQ-011 SHALL have port erro, output, 1: invalid tamanho or unsupported opcode.
REQ-012 SHALL have port busy, output, 1: high from the cycle after acceptance through the DONE cycle.
REQ-013 SHALL have port done, output, 1: single-cycle completion pulse.

Function
REQ-014 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-015 Acceptance (IDLE and start=1) SHALL latch op, tamanho, matriz1 and matriz2, clear matrizresult, overflow and erro, and zero the indices i, j, k.
REQ-016 A start seen outside IDLE SHALL be ignored; operands SHALL NOT be resampled during CALC.
REQ-017 Opcodes SHALL be: 000 add, 001 sub, 010 oposta, 011 mult, 100 transposta, 110 scalar mult (scalar = matriz2 element (0,0)), 111 clear, 101 unsupported.
REQ-018 Element ops (add, sub, oposta, transposta, scalar) SHALL produce one result element per CALC cycle, row-major, for n*n cycles.
REQ-019 Mult SHALL perform one MAC per CALC cycle (k innermost), for n*n*n cycles.
REQ-020 The mult accumulator SHALL be 2*DATA_W+3 bits wide; the element SHALL be written, truncated to DATA_W, on k = n-1.
REQ-021 Each element SHALL be truncated to DATA_W; overflow SHALL be set if the full-precision value lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-022 Oposta of -2^(DATA_W-1) SHALL set overflow.
REQ-023 Result elements with i >= n or j >= n SHALL remain 0.
REQ-024 Clear, op 101, or tamanho outside 2..N_MAX SHALL go IDLE -> DONE directly with matrizresult = 0.
REQ-025 In the REQ-024 case, erro SHALL be 1 for op 101 or invalid tamanho, and 0 for clear.
REQ-026 done SHALL be 1 only in the DONE state; in that cycle matrizresult, overflow and erro SHALL be final.
REQ-027 Outputs SHALL hold those values until the next acceptance.
REQ-028 Latency (start cycle = 0) SHALL be: done at cycle n*n+1 for element ops, n*n*n+1 for mult, and 1 for immediate ops.
REQ-029 start held high continuously SHALL begin a new operation in the IDLE cycle following DONE.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE.
REQ-031 That reset SHALL zero matrizresult, overflow, erro, busy, done, all indices and the accumulator.
REQ-032 rst SHALL take priority over start.
REQ-033 Reset during CALC SHALL abort the operation with no done pulse.

Structure
REQ-034 Package coprocessador_pkg SHALL hold the opcode constants, the FSM state encoding, and the default DATA_W and N_MAX.
REQ-035 Sub-module elemento_alu SHALL be the combinational per-element datapath: add, sub, negate, scalar multiply, with DATA_W truncation and overflow detect.
REQ-036 The top level SHALL own the FSM, index counters, MAC accumulator, operand and result registers.

Verification
REQ-037 Add: n=2, op 000, A=[1,2;3,4], B=[5,6;7,8] -> done at cycle 5, result [6,8;10,12], overflow 0, others 0.
REQ-038 Mult: n=3, op 011, A=identity, B=[1..9] row-major -> done at cycle 28, result = B, overflow 0.
REQ-039 Overflow: n=2, op 000, A(0,0)=100, B(0,0)=100 -> result(0,0) = -56 (0xC8), overflow 1; op 010 with A(0,0) = -128 -> overflow 1.
REQ-040 Error: tamanho=6 or op 101 -> done at cycle 1, erro 1, result 0; op 111 -> done at cycle 1, erro 0.
REQ-041 Reset mid-operation: n=5 mult, rst at cycle 40 -> no done pulse, all outputs 0 next cycle; a new start is then accepted normally.
REQ-042 Start while busy: n=4 transposta, start re-pulsed with different operands at cycle 3 -> ignored, result = transpose of the original A, single done pulse at cycle 17.

Source files
------------

// File: rtl/coprocessador_pkg.sv
// coprocessador_pkg: opcodes, FSM states, ALU ops and default sizes for the matrix coprocessor
package coprocessador_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int N_MAX_DEF = 5;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OPO = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_TRN = 3'b100;
  localparam logic [2:0] OP_UNS = 3'b101;
  localparam logic [2:0] OP_SCL = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_NEG, ALU_SCL} alu_op_t;
endpackage

// File: rtl/elemento_alu.sv
// elemento_alu: combinational per-element add/sub/negate/scalar-multiply with truncation and overflow flag
module elemento_alu
  import coprocessador_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  alu_op_t                  i_op,
  output logic signed [DATA_W-1:0] o_y,
  output logic                     o_ovf
);
  localparam int FW = 2*DATA_W+1;
  logic signed [FW-1:0] w_a, w_b, w_full;
  always_comb begin
    w_a = {{(FW-DATA_W){i_a[DATA_W-1]}}, i_a};
    w_b = {{(FW-DATA_W){i_b[DATA_W-1]}}, i_b};
    w_full = (i_op == ALU_SUB) ? w_a - w_b :
             (i_op == ALU_NEG) ? -w_a :
             (i_op == ALU_SCL) ? w_a * w_b : w_a + w_b;
    o_y = w_full[DATA_W-1:0];
    o_ovf = w_full != {{(FW-DATA_W){w_full[DATA_W-1]}}, w_full[DATA_W-1:0]};
  end
endmodule

// File: rtl/coprocessador_param.sv
// coprocessador_param: sequential matrix coprocessor, one element (or one MAC) per cycle
module coprocessador_param
  import coprocessador_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_MAX = N_MAX_DEF,
  localparam int M_W = N_MAX*N_MAX*DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     tamanho,
  input  logic [2:0]     op,
  input  logic [M_W-1:0] matriz1,
  input  logic [M_W-1:0] matriz2,
  output logic [M_W-1:0] matrizresult,
  output logic           overflow,
  output logic           erro,
  output logic           busy,
  output logic           done
);
  localparam int AW = 2*DATA_W+3;
  localparam logic [2:0] N_TOP = 3'(N_MAX);
  typedef logic signed [DATA_W-1:0] elem_t;
  state_t r_state;
  logic [2:0] r_op, r_n, r_i, r_j, r_k;
  logic [AW-1:0] r_acc;
  logic r_ovf, r_erro;
  elem_t r_a [N_MAX][N_MAX];
  elem_t r_b [N_MAX][N_MAX];
  elem_t r_res [N_MAX][N_MAX];
  elem_t w_a, w_b, w_y;
  alu_op_t w_alu_op;
  logic w_alu_ovf, w_mac_ovf, w_last_i, w_last_j, w_last_k, w_step, w_bad, w_imm;
  logic signed [2*DATA_W-1:0] w_pa, w_pb, w_prod;
  logic [AW-1:0] w_acc_nx;
  always_comb begin
    w_a = (r_op == OP_TRN) ? r_a[r_j][r_i] : r_a[r_i][r_j];
    w_b = (r_op == OP_SCL) ? r_b[0][0] : (r_op == OP_TRN) ? '0 : r_b[r_i][r_j];
    w_alu_op = (r_op == OP_SUB) ? ALU_SUB : (r_op == OP_OPO) ? ALU_NEG :
               (r_op == OP_SCL) ? ALU_SCL : ALU_ADD;
    w_pa = {{DATA_W{r_a[r_i][r_k][DATA_W-1]}}, r_a[r_i][r_k]};
    w_pb = {{DATA_W{r_b[r_k][r_j][DATA_W-1]}}, r_b[r_k][r_j]};
    w_prod = w_pa * w_pb;
    w_acc_nx = ((r_k == 3'd0) ? '0 : r_acc) + {{3{w_prod[2*DATA_W-1]}}, w_prod};
    w_mac_ovf = w_acc_nx != {{(AW-DATA_W){w_acc_nx[DATA_W-1]}}, w_acc_nx[DATA_W-1:0]};
    w_last_i = r_i == r_n - 3'd1;
    w_last_j = r_j == r_n - 3'd1;
    w_last_k = r_k == r_n - 3'd1;
    w_step = (r_op != OP_MUL) || w_last_k;
    w_bad = (tamanho < 3'd2) || (tamanho > N_TOP) || (op == OP_UNS);
    w_imm = w_bad || (op == OP_CLR);
  end
  elemento_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a(w_a), .i_b(w_b), .i_op(w_alu_op), .o_y(w_y), .o_ovf(w_alu_ovf)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op <= '0;
      r_n <= '0;
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_erro <= 1'b0;
      r_a <= '{default: '0};
      r_b <= '{default: '0};
      r_res <= '{default: '0};
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) begin
          r_op <= op;
          r_n <= tamanho;
          for (int x = 0; x < N_MAX; x++)
            for (int y = 0; y < N_MAX; y++) begin
              r_a[x][y] <= matriz1[(x*N_MAX+y)*DATA_W +: DATA_W];
              r_b[x][y] <= matriz2[(x*N_MAX+y)*DATA_W +: DATA_W];
            end
          r_res <= '{default: '0};
          r_ovf <= 1'b0;
          r_erro <= w_bad;
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
          r_acc <= '0;
          r_state <= w_imm ? ST_DONE : ST_CALC;
        end
        ST_CALC: begin
          if (r_op == OP_MUL) begin
            r_acc <= w_acc_nx;
            r_k <= w_last_k ? 3'd0 : r_k + 3'd1;
            if (w_last_k) begin
              r_res[r_i][r_j] <= w_acc_nx[DATA_W-1:0];
              r_ovf <= r_ovf | w_mac_ovf;
            end
          end else begin
            r_res[r_i][r_j] <= w_y;
            r_ovf <= r_ovf | w_alu_ovf;
          end
          if (w_step) begin
            r_j <= w_last_j ? 3'd0 : r_j + 3'd1;
            if (w_last_j) r_i <= r_i + 3'd1;
            if (w_last_i && w_last_j) r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  for (genvar g = 0; g < N_MAX; g++) begin : g_row
    for (genvar h = 0; h < N_MAX; h++) begin : g_col
      assign matrizresult[(g*N_MAX+h)*DATA_W +: DATA_W] = r_res[g][h];
    end
  end
  assign overflow = r_ovf;
  assign erro = r_erro;
  assign busy = r_state != ST_IDLE;
  assign done = r_state == ST_DONE;
endmodule

// File: tb/tb_coprocessador_param.sv
// tb_coprocessador_param: directed and random checks against an arithmetic matrix model
module tb_coprocessador_param;
  localparam int W = 8;
  localparam int N = 5;
  localparam int MW = N*N*W;
  logic clk = 1'b0;
  logic rst, start, overflow, erro, busy, done;
  logic [2:0] tamanho, op;
  logic [MW-1:0] matriz1, matriz2, matrizresult;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  coprocessador_param dut (
    .clk(clk), .rst(rst), .start(start), .tamanho(tamanho), .op(op),
    .matriz1(matriz1), .matriz2(matriz2), .matrizresult(matrizresult),
    .overflow(overflow), .erro(erro), .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int el(input logic [MW-1:0] m, input int i, input int j);
    return int'($signed(m[(i*N+j)*W +: W]));
  endfunction

  function automatic void setel(inout logic [MW-1:0] m, input int i, input int j, input int v);
    m[(i*N+j)*W +: W] = v[W-1:0];
  endfunction

  function automatic logic [MW-1:0] randmat();
    logic [MW-1:0] m;
    for (int i = 0; i < N*N; i++) m[i*W +: W] = W'($urandom);
    return m;
  endfunction

  // Mathematical definition of each operation on integers, then truncation.
  function automatic void model(input logic [2:0] o, input logic [2:0] t,
                                input logic [MW-1:0] a, input logic [MW-1:0] b,
                                output logic [MW-1:0] r, output logic ov,
                                output logic er, output int lat);
    int n, v;
    n = int'(t);
    r = '0;
    ov = 1'b0;
    er = (o == 3'b101) || (n < 2) || (n > N);
    lat = 1;
    if (er || o == 3'b111) return;
    lat = (o == 3'b011) ? n*n*n + 1 : n*n + 1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        case (o)
          3'b000: v = el(a, i, j) + el(b, i, j);
          3'b001: v = el(a, i, j) - el(b, i, j);
          3'b010: v = -el(a, i, j);
          3'b011: begin
            v = 0;
            for (int k = 0; k < n; k++) v += el(a, i, k) * el(b, k, j);
          end
          3'b100: v = el(a, j, i);
          default: v = el(a, i, j) * el(b, 0, 0);
        endcase
        if (v < -(1 << (W-1)) || v > (1 << (W-1)) - 1) ov = 1'b1;
        setel(r, i, j, v);
      end
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [2:0] t, input logic [MW-1:0] a,
                        input logic [MW-1:0] b, input string tag, input int rp);
    logic [MW-1:0] er_m, cap_res;
    logic e_ov, e_er, cap_ov, cap_er, cap_busy;
    int lat, first, ndone;
    model(o, t, a, b, er_m, e_ov, e_er, lat);
    op = o; tamanho = t; matriz1 = a; matriz2 = b; start = 1'b1;
    first = 0; ndone = 0;
    cap_res = 'x; cap_ov = 1'bx; cap_er = 1'bx; cap_busy = 1'bx;
    for (int c = 1; c <= lat + 3; c++) begin
      tick;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = c; cap_res = matrizresult; cap_ov = overflow; cap_er = erro; cap_busy = busy;
        end
      end
      if (c == 1) begin
        start = 1'b0; matriz1 = randmat(); matriz2 = randmat();
        op = 3'($urandom); tamanho = 3'($urandom);
      end
      if (c == rp) begin
        start = 1'b1; op = 3'b000; tamanho = 3'd2; matriz1 = randmat(); matriz2 = randmat();
      end
      if (c == rp + 1) start = 1'b0;
    end
    chk({tag, "_lat"}, MW'(first), MW'(lat));
    chk({tag, "_ndone"}, MW'(ndone), MW'(1));
    chk({tag, "_res"}, cap_res, er_m);
    chk({tag, "_ovf"}, cap_ov, e_ov);
    chk({tag, "_erro"}, cap_er, e_er);
    chk({tag, "_busy_done"}, cap_busy, 1'b1);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    chk({tag, "_hold"}, matrizresult, er_m);
  endtask

  initial begin
    logic [MW-1:0] a, b, exp_r;
    logic e_ov, e_er, bz [1:14];
    int lat, d1, d2, nd;
    rst = 1'b1; start = 1'b0; op = '0; tamanho = '0; matriz1 = '0; matriz2 = '0;
    tick;
    tick;
    chk("rst_res", matrizresult, '0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_erro", erro, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    start = 1'b1; op = 3'b000; tamanho = 3'd2;
    tick;
    chk("rst_prio", busy, 1'b0);
    rst = 1'b0; start = 1'b0;
    tick;

    a = '0; b = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        setel(a, i, j, i*2 + j + 1);
        setel(b, i, j, i*2 + j + 5);
      end
    run_op(3'b000, 3'd2, a, b, "add2", 0);
    chk("add2_const", matrizresult, MW'(56'h0C0A0000000806));

    a = '0; b = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        setel(a, i, j, (i == j) ? 1 : 0);
        setel(b, i, j, i*3 + j + 1);
      end
    run_op(3'b011, 3'd3, a, b, "mul3", 0);
    chk("mul3_eq_b", matrizresult, b);

    a = '0; b = '0;
    setel(a, 0, 0, 100); setel(b, 0, 0, 100);
    run_op(3'b000, 3'd2, a, b, "ovf_add", 0);
    chk("ovf_add_c8", matrizresult[7:0], 8'hC8);
    a = '0; setel(a, 0, 0, -128);
    run_op(3'b010, 3'd2, a, b, "ovf_neg", 0);

    run_op(3'b011, 3'd2, randmat(), randmat(), "pre_clr", 0);
    run_op(3'b000, 3'd6, randmat(), randmat(), "bad_n6", 0);
    run_op(3'b101, 3'd3, randmat(), randmat(), "op101", 0);
    run_op(3'b111, 3'd3, randmat(), randmat(), "clear", 0);
    run_op(3'b001, 3'd1, randmat(), randmat(), "bad_n1", 0);
    run_op(3'b001, 3'd0, randmat(), randmat(), "bad_n0", 0);

    run_op(3'b100, 3'd4, randmat(), randmat(), "trn_repulse", 3);

    a = '0; b = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        setel(a, i, j, i*2 + j + 1);
        setel(b, i, j, i*2 + j + 5);
      end
    model(3'b000, 3'd2, a, b, exp_r, e_ov, e_er, lat);
    op = 3'b000; tamanho = 3'd2; matriz1 = a; matriz2 = b; start = 1'b1;
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 14; c++) begin
      tick;
      bz[c] = busy;
      if (done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (c == 7) start = 1'b0;
    end
    chk("hold_d1", MW'(d1), MW'(5));
    chk("hold_d2", MW'(d2), MW'(11));
    chk("hold_idle_gap", bz[6], 1'b0);
    chk("hold_reaccept", bz[7], 1'b1);
    chk("hold_res", matrizresult, exp_r);

    op = 3'b011; tamanho = 3'd5; matriz1 = randmat(); matriz2 = randmat(); start = 1'b1;
    nd = 0;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (c == 1) start = 1'b0;
      if (done) nd++;
    end
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick;
    chk("abort_nodone", MW'(nd), '0);
    chk("abort_res", matrizresult, '0);
    chk("abort_ovf", overflow, 1'b0);
    chk("abort_erro", erro, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    rst = 1'b0;
    tick;
    run_op(3'b001, 3'd3, randmat(), randmat(), "after_abort", 0);

    for (int it = 0; it < 18; it++)
      run_op(3'($urandom_range(0, 7)), 3'($urandom_range(2, 5)), randmat(), randmat(),
             $sformatf("rnd%0d", it), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
